// File: rtl/serial_alu_pkg.sv
// Shared op codes, FSM states and flag indices for the digit-serial ALU.
// Op-class helpers keep decode identical across the top and the digit unit.
package serial_alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_ADC  = 4'd2;
    localparam logic [OP_W-1:0] OP_SBC  = 4'd3;
    localparam logic [OP_W-1:0] OP_AND  = 4'd4;
    localparam logic [OP_W-1:0] OP_OR   = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_MOV  = 4'd7;
    localparam logic [OP_W-1:0] OP_CMP  = 4'd8;
    localparam logic [OP_W-1:0] OP_SHL1 = 4'd9;
    localparam logic [OP_W-1:0] OP_SHR1 = 4'd10;
    localparam logic [OP_W-1:0] OP_SAR1 = 4'd11;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_Z = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) ||
               (op == OP_SBC) || (op == OP_CMP);
    endfunction

    function automatic logic is_sub(input logic [OP_W-1:0] op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
    endfunction

    function automatic logic is_shift_right(input logic [OP_W-1:0] op);
        return (op == OP_SHR1) || (op == OP_SAR1);
    endfunction

endpackage

// File: rtl/serial_digit_unit.sv
// Combinational per-digit datapath: adder/subtractor, logic ops and shift-digit
// formation. Right-shift digits take their top bit from a[0] of the next digit.
module serial_digit_unit
    import serial_alu_pkg::*;
#(
    parameter int unsigned NSHIFT = 2
) (
    input  logic [NSHIFT-1:0] a,
    input  logic [NSHIFT-1:0] b,
    input  logic              cin,
    input  logic [OP_W-1:0]   op,
    input  logic [NSHIFT-1:0] hold_digit,
    output logic [NSHIFT-1:0] digit,
    output logic              cout,
    output logic              vout
);

    localparam int unsigned SW = NSHIFT + 1;

    logic [NSHIFT-1:0] bb;
    logic [SW-1:0]     sum;

    assign bb  = is_sub(op) ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bb} + SW'(cin);

    always_comb begin
        digit = '0;
        cout  = 1'b0;
        vout  = 1'b0;
        if (is_arith(op)) begin
            digit = sum[NSHIFT-1:0];
            cout  = sum[NSHIFT];
            // carry into the MSB recovered from the MSB sum bit
            vout  = (a[NSHIFT-1] ^ bb[NSHIFT-1] ^ sum[NSHIFT-1]) ^ sum[NSHIFT];
        end else begin
            case (op)
                OP_AND:  digit = a & b;
                OP_OR:   digit = a | b;
                OP_XOR:  digit = a ^ b;
                OP_MOV:  digit = b;
                OP_SHL1: begin
                    digit = {a[NSHIFT-2:0], cin};
                    cout  = a[NSHIFT-1];
                end
                OP_SHR1, OP_SAR1: begin
                    digit = {a[0], hold_digit[NSHIFT-1:1]};
                    cout  = hold_digit[0];
                end
                default: digit = '0;
            endcase
        end
    end

endmodule

// File: rtl/serial_alu_n.sv
// Digit-serial ALU top: command latch, FSM, digit counter, carry and hold
// registers, registered result stream and persistent C/V/S/Z flags.
module serial_alu_n
    import serial_alu_pkg::*;
#(
    parameter int unsigned NSHIFT     = 2,
    parameter int unsigned MAX_DIGITS = 16,
    parameter int unsigned LEN_BITS   = $clog2(MAX_DIGITS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [LEN_BITS-1:0] cmd_len_m1,
    input  logic                cmd_flags,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NSHIFT-1:0]   in_a,
    input  logic [NSHIFT-1:0]   in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NSHIFT-1:0]   out_digit,
    output logic                out_last,
    output logic                flag_c,
    output logic                flag_v,
    output logic                flag_s,
    output logic                flag_z
);

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] cnt_q;
    logic                flags_en_q;
    logic                carry_q;
    logic [NSHIFT-1:0]   hold_q;
    logic                first_c_q;
    logic                z_acc_q;
    logic [FLAG_W-1:0]   flags_q;

    logic                cmd_fire, in_fire, out_fire, flush_go;
    logic                op_sr, last_in, out_load, load_last;
    logic                first_cin, du_cin, fill;
    logic [NSHIFT-1:0]   du_a, du_digit;
    logic                du_cout, du_vout;

    assign cmd_ready = (state_q == IDLE);
    assign in_ready  = (state_q == RUN) && (!out_valid || out_ready);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign flush_go  = (state_q == FLUSH) && (!out_valid || out_ready);

    assign op_sr     = is_shift_right(op_q);
    assign last_in   = (cnt_q == len_q);
    // the first right-shift digit only primes the hold register
    assign out_load  = (in_fire && !(op_sr && (cnt_q == '0))) || flush_go;
    assign load_last = flush_go || (in_fire && last_in && !op_sr);

    always_comb begin
        first_cin = 1'b0;
        case (op_q)
            OP_ADC, OP_SBC: first_cin = flag_c;
            OP_SUB, OP_CMP: first_cin = 1'b1;
            default:        first_cin = 1'b0;
        endcase
    end

    assign du_cin = (cnt_q == '0) ? first_cin : carry_q;
    assign fill   = (op_q == OP_SAR1) && hold_q[NSHIFT-1];
    assign du_a   = (state_q == FLUSH) ? {NSHIFT{fill}} : in_a;

    serial_digit_unit #(.NSHIFT(NSHIFT)) u_digit (
        .a          (du_a),
        .b          (in_b),
        .cin        (du_cin),
        .op         (op_q),
        .hold_digit (hold_q),
        .digit      (du_digit),
        .cout       (du_cout),
        .vout       (du_vout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire) state_d = RUN;
            RUN:     if (in_fire && last_in) state_d = op_sr ? FLUSH : IDLE;
            FLUSH:   if (flush_go) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= OP_ADD;
            len_q      <= '0;
            cnt_q      <= '0;
            flags_en_q <= 1'b0;
            carry_q    <= 1'b0;
            hold_q     <= '0;
            first_c_q  <= 1'b0;
            z_acc_q    <= 1'b0;
            flags_q    <= '0;
            out_valid  <= 1'b0;
            out_digit  <= '0;
            out_last   <= 1'b0;
        end else begin
            if (cmd_fire) begin
                op_q       <= cmd_op;
                len_q      <= cmd_len_m1;
                flags_en_q <= cmd_flags;
                cnt_q      <= '0;
                carry_q    <= 1'b0;
                z_acc_q    <= 1'b1;
            end
            if (in_fire) begin
                if (!last_in) cnt_q <= cnt_q + LEN_BITS'(1);
                carry_q <= du_cout;
                hold_q  <= in_a;
                if (cnt_q == '0) first_c_q <= in_a[0];
            end
            if (out_load) begin
                out_valid <= 1'b1;
                out_digit <= du_digit;
                out_last  <= load_last;
                z_acc_q   <= z_acc_q & (du_digit == '0);
                if (load_last && flags_en_q) begin
                    flags_q[FLAG_C] <= op_sr ? first_c_q : du_cout;
                    flags_q[FLAG_V] <= du_vout;
                    flags_q[FLAG_S] <= du_digit[NSHIFT-1];
                    flags_q[FLAG_Z] <= z_acc_q & (du_digit == '0);
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign flag_c = flags_q[FLAG_C];
    assign flag_v = flags_q[FLAG_V];
    assign flag_s = flags_q[FLAG_S];
    assign flag_z = flags_q[FLAG_Z];

endmodule

// File: tb/tb_serial_alu_n.sv
// Self-checking bench for serial_alu_n: directed scenarios plus randomized ops
// with backpressure, compared against a whole-word arithmetic reference model.
module tb_serial_alu_n;
    import serial_alu_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned LB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = 4'd0;
    logic [LB-1:0] cmd_len_m1 = '0;
    logic          cmd_flags = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_digit;
    logic          out_last;
    logic          flag_c, flag_v, flag_s, flag_z;

    int checks = 0;
    int errors = 0;
    bit m_c = 0, m_v = 0, m_s = 0, m_z = 0;
    int g_tlast, g_tlat;

    always #5 clk = ~clk;

    serial_alu_n #(.NSHIFT(N), .MAX_DIGITS(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len_m1(cmd_len_m1), .cmd_flags(cmd_flags),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_last(out_last),
        .flag_c(flag_c), .flag_v(flag_v), .flag_s(flag_s), .flag_z(flag_z)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // whole-word reference: result and flags from plain arithmetic
    task automatic model(input logic [3:0] op, input int len_m1,
                         input longint unsigned a, input longint unsigned b,
                         input bit fl, output longint unsigned r);
        int w;
        longint unsigned mask, bb, full, cin;
        bit c, v;
        w = N * (len_m1 + 1);
        mask = (64'd1 << w) - 64'd1;
        c = 0; v = 0; r = 0; cin = 0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                bb = (op == OP_SUB || op == OP_SBC || op == OP_CMP) ? (~b & mask) : b;
                if (op == OP_SUB || op == OP_CMP) cin = 1;
                else if (op == OP_ADC || op == OP_SBC) cin = longint'(m_c);
                full = a + bb + cin;
                r = full & mask;
                c = full[w];
                v = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_MOV:  r = b;
            OP_SHL1: begin r = (a << 1) & mask; c = a[w-1]; end
            OP_SHR1: begin r = a >> 1; c = a[0]; end
            OP_SAR1: begin r = (a >> 1) | (a & (64'd1 << (w - 1))); c = a[0]; end
            default: r = 0;
        endcase
        if (fl) begin
            m_c = c; m_v = v; m_s = r[w-1]; m_z = (r == 0);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input int len_m1,
                          input longint unsigned a, input longint unsigned b, input bit fl,
                          input int rdy_pct, input int val_pct,
                          output longint unsigned res, output int t_last, output int t_lat);
        int idx, oi, t_in0, t_out0;
        bit done;
        res = 0; idx = 0; oi = 0; t_in0 = -1; t_out0 = -1; t_last = -1; done = 0;
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        cmd_valid = 1; cmd_op = op; cmd_len_m1 = LB'(len_m1); cmd_flags = fl;
        #1 check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
        @(posedge clk);
        for (int k = 1; k <= 3000 && !done; k++) begin
            @(negedge clk);
            cmd_valid = 0;
            in_valid  = int'($urandom_range(99)) < val_pct;
            in_a = (idx <= len_m1) ? N'(a >> (idx * N)) : N'($urandom);
            in_b = (idx <= len_m1) ? N'(b >> (idx * N)) : N'($urandom);
            out_ready = int'($urandom_range(99)) < rdy_pct;
            #1;
            if (out_valid && !out_ready)
                check({tag, " in_ready stall"}, 64'(in_ready), 64'd0);
            if (in_valid && idx > len_m1)
                check({tag, " in_ready beyond len"}, 64'(in_ready), 64'd0);
            if (out_valid && t_out0 < 0) t_out0 = k;
            if (out_valid && out_ready) begin
                res |= longint'(out_digit) << (oi * N);
                check({tag, " out_last"}, 64'(out_last), 64'(oi == len_m1));
                if (oi == len_m1) begin done = 1; t_last = k; end
                oi++;
            end
            if (in_valid && in_ready) begin
                if (t_in0 < 0) t_in0 = k;
                idx++;
            end
            @(posedge clk);
        end
        if (!done) check({tag, " timeout"}, 64'd0, 64'd1);
        t_lat = t_out0 - t_in0;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input int len_m1,
                         input longint unsigned a, input longint unsigned b, input bit fl,
                         input int rdy_pct, input int val_pct, output longint unsigned got);
        longint unsigned exp_r;
        model(op, len_m1, a, b, fl, exp_r);
        run_op(tag, op, len_m1, a, b, fl, rdy_pct, val_pct, got, g_tlast, g_tlat);
        check({tag, " result"}, got, exp_r);
        check({tag, " C"}, 64'(flag_c), 64'(m_c));
        check({tag, " V"}, 64'(flag_v), 64'(m_v));
        check({tag, " S"}, 64'(flag_s), 64'(m_s));
        check({tag, " Z"}, 64'(flag_z), 64'(m_z));
    endtask

    initial begin
        longint unsigned r, a, b;
        int len;
        logic [3:0] op;

        #12;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_digit", 64'(out_digit), 64'd0);
        check("reset out_last", 64'(out_last), 64'd0);
        check("reset cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset flags", 64'({flag_c, flag_v, flag_s, flag_z}), 64'd0);
        @(negedge clk) reset_n = 1;

        do_op("add7f", OP_ADD, 3, 'h7F, 'h01, 1, 100, 100, r);
        check("add7f const", r, 64'h80);
        check("add7f flags", 64'({flag_c, flag_v, flag_s, flag_z}), 64'b0110);
        check("add7f latency", 64'(g_tlast), 64'd5);
        check("add7f first out", 64'(g_tlat), 64'd1);

        do_op("sub", OP_SUB, 3, 'h00, 'h01, 1, 100, 100, r);
        check("sub const", r, 64'hFF);
        do_op("cmp", OP_CMP, 3, 'h05, 'h05, 1, 100, 100, r);
        check("cmp CZ", 64'({flag_c, flag_z}), 64'b11);

        do_op("chain lo", OP_ADD, 3, 'hFF, 'h01, 1, 100, 100, r);
        check("chain lo C", 64'(flag_c), 64'd1);
        do_op("chain hi", OP_ADC, 3, 'h00, 'h00, 1, 100, 100, r);
        check("chain hi const", r, 64'h01);

        do_op("sar1", OP_SAR1, 3, 'h81, 'h00, 1, 100, 100, r);
        check("sar1 const", r, 64'hC0);
        check("sar1 latency", 64'(g_tlast), 64'd6);
        check("sar1 first out", 64'(g_tlat), 64'd2);
        do_op("shr1", OP_SHR1, 3, 'h81, 'h00, 1, 100, 100, r);
        check("shr1 const", r, 64'h40);

        do_op("sar1 len1", OP_SAR1, 0, 'h2, 'h0, 1, 100, 100, r);
        check("sar1 len1 const", r, 64'h3);
        do_op("shr1 len1", OP_SHR1, 0, 'h3, 'h0, 1, 100, 100, r);
        do_op("add len1", OP_ADD, 0, 'h3, 'h1, 1, 100, 100, r);
        do_op("shl1", OP_SHL1, 3, 'hC1, 'h0, 1, 70, 100, r);
        do_op("sbc", OP_SBC, 3, 'h10, 'h20, 1, 70, 90, r);
        do_op("noflags", OP_AND, 3, 'h00, 'hFF, 0, 70, 90, r);

        for (int i = 0; i < 50; i++) begin
            a = longint'($urandom) & 64'hFFFF;
            b = longint'($urandom) & 64'hFFFF;
            do_op("xor bp", OP_XOR, 7, a, b, 1, 50, 80, r);
        end

        // set S=1 then reset while an output digit is stalled
        do_op("pre-reset", OP_SUB, 3, 'h00, 'h01, 1, 100, 100, r);
        @(negedge clk);
        cmd_valid = 1; cmd_op = OP_ADD; cmd_len_m1 = LB'(3); cmd_flags = 1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0; in_valid = 1; in_a = 2'd3; in_b = 2'd0; out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        in_a = 2'd1;
        #1;
        check("stall out_valid", 64'(out_valid), 64'd1);
        check("stall out_digit", 64'(out_digit), 64'd3);
        check("stall in_ready", 64'(in_ready), 64'd0);
        #1 reset_n = 0;
        #1;
        check("async out_valid", 64'(out_valid), 64'd0);
        check("async out_digit", 64'(out_digit), 64'd0);
        check("async cmd_ready", 64'(cmd_ready), 64'd1);
        check("async flags", 64'({flag_c, flag_v, flag_s, flag_z}), 64'd0);
        m_c = 0; m_v = 0; m_s = 0; m_z = 0;
        @(negedge clk);
        in_valid = 0; reset_n = 1;
        do_op("post-reset adc", OP_ADC, 3, 'h10, 'h20, 1, 100, 100, r);
        check("post-reset const", r, 64'h30);

        for (int i = 0; i < 1000; i++) begin
            op  = 4'($urandom_range(11));
            len = int'($urandom_range(15));
            a = longint'($urandom) & ((64'd1 << (N * (len + 1))) - 64'd1);
            b = longint'($urandom) & ((64'd1 << (N * (len + 1))) - 64'd1);
            do_op("rnd", op, len, a, b, $urandom_range(9) < 7, 60, 80, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
